// File: rtl/cnn_processor.sv
// cnn_processor: 3x3 valid conv + bias + ReLU/saturate + 2x2 max-pool engine over an 8x8 tile.
module cnn_processor #(
  parameter int IMG_DIM = 8,
  parameter int DATA_WIDTH = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter int IMG_ADDR_WIDTH = 6,
  parameter int POOL_OUT_ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           done,
  input  logic [IMG_ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           wr_en,
  input  logic                           mem_select,
  input  logic [POOL_OUT_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]          data_out
);
  localparam int CD = IMG_DIM - 2;
  localparam int PD = CD / 2;
  typedef enum logic [1:0] {IDLE, CONV, POOL, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] img [IMG_DIM*IMG_DIM];
  logic signed [WEIGHT_WIDTH-1:0] w [9];
  logic signed [BIAS_WIDTH-1:0] bias;
  logic [DATA_WIDTH-1:0] conv_buf [CD*CD];
  logic [DATA_WIDTH-1:0] out_ram [PD*PD];
  logic [2:0] r, c, q;
  logic [1:0] ki, kj, pr, pc;
  logic signed [ACC_WIDTH-1:0] acc, prod, sum;
  logic [DATA_WIDTH-1:0] pix, relu, v, mx;
  logic [IMG_ADDR_WIDTH-1:0] pix_idx;
  logic [5:0] conv_idx, pool_idx;
  logic [3:0] w_idx, out_idx;
  logic idle;
  always_comb begin
    idle = state == IDLE || state == DONE;
    pix_idx = IMG_ADDR_WIDTH'(32'(r + 3'(ki)) * IMG_DIM + 32'(c + 3'(kj)));
    w_idx = 4'(ki) * 4'd3 + 4'(kj);
    pix = img[pix_idx];
    prod = $signed({1'b0, pix}) * w[w_idx];
    sum = ((ki == 2'd0 && kj == 2'd0) ? ACC_WIDTH'(bias) : acc) + prod;
    relu = acc[ACC_WIDTH-1] ? '0 : (|acc[ACC_WIDTH-2:DATA_WIDTH]) ? '1 : acc[DATA_WIDTH-1:0];
    conv_idx = 6'(32'(r) * CD + 32'(c));
    pool_idx = 6'(32'({pr, 1'b0} + 3'(q[1])) * CD + 32'({pc, 1'b0} + 3'(q[0])));
    v = conv_buf[pool_idx];
    out_idx = 4'(pr) * 4'd3 + 4'(pc);
    data_out = (32'(rd_addr) < PD * PD) ? out_ram[rd_addr] : '0;
  end
  // Image and kernel memories deliberately survive reset.
  always_ff @(posedge clk)
    if (wr_en && idle) begin
      if (!mem_select) img[wr_addr] <= data_in;
      else if (wr_addr < 6'd9) w[wr_addr[3:0]] <= data_in;
      else if (wr_addr == 6'd9) bias <= {{(BIAS_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      {r, c, q, ki, kj, pr, pc} <= '0;
      acc <= '0;
      mx <= '0;
      for (int i = 0; i < CD*CD; i++) conv_buf[i] <= '0;
      for (int i = 0; i < PD*PD; i++) out_ram[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= CONV;
            done <= 1'b0;
            {r, c, ki, kj} <= '0;
          end else if (state == DONE) done <= 1'b1;
        end
        CONV: begin
          // ki==3 marks the store slot after the nine MAC steps.
          if (ki == 2'd3) begin
            conv_buf[conv_idx] <= relu;
            ki <= '0;
            c <= (c == 3'(CD-1)) ? '0 : c + 3'd1;
            if (c == 3'(CD-1)) begin
              r <= r + 3'd1;
              if (r == 3'(CD-1)) begin
                state <= POOL;
                {pr, pc, q} <= '0;
              end
            end
          end else begin
            acc <= sum;
            kj <= (kj == 2'd2) ? '0 : kj + 2'd1;
            if (kj == 2'd2) ki <= ki + 2'd1;
          end
        end
        POOL: begin
          if (q == 3'd4) begin
            out_ram[out_idx] <= mx;
            q <= '0;
            pc <= (pc == 2'(PD-1)) ? '0 : pc + 2'd1;
            if (pc == 2'(PD-1)) begin
              pr <= pr + 2'd1;
              if (pr == 2'(PD-1)) state <= DONE;
            end
          end else begin
            mx <= (q == 3'd0 || v > mx) ? v : mx;
            q <= q + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_processor.sv
// tb_cnn_processor: table vectors, corner sequences and random tiles against an arithmetic model.
module tb_cnn_processor;
  logic clk = 0, rst = 1, start = 0, wr_en = 0, mem_select = 0, done;
  logic [5:0] wr_addr = 0;
  logic [7:0] data_in = 0, data_out;
  logic [3:0] rd_addr = 0;
  int checks = 0, errors = 0;
  int tb_img [64];
  int tb_w [9];
  int tb_bias;
  typedef struct {
    int pmode;
    int wmode;
    int wfill;
    int bias;
    logic [71:0] exp;
  } vec_t;
  vec_t vecs [4];

  cnn_processor dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .wr_addr(wr_addr),
    .data_in(data_in), .wr_en(wr_en), .mem_select(mem_select),
    .rd_addr(rd_addr), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [71:0] model();
    int conv [6][6];
    logic [71:0] e;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        int s = tb_bias;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) s += tb_img[(r+i)*8 + c+j] * tb_w[i*3+j];
        conv[r][c] = s < 0 ? 0 : s > 255 ? 255 : s;
      end
    for (int p = 0; p < 9; p++) begin
      int m = 0;
      for (int d = 0; d < 4; d++) begin
        int x = conv[(p/3)*2 + d/2][(p%3)*2 + d%2];
        if (x > m) m = x;
      end
      e[p*8 +: 8] = 8'(m);
    end
    return e;
  endfunction

  task automatic wr(input logic sel, input int a, input int d);
    @(negedge clk);
    wr_en = 1; mem_select = sel; wr_addr = 6'(a); data_in = 8'(d);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic load();
    for (int i = 0; i < 64; i++) wr(0, i, tb_img[i]);
    for (int k = 0; k < 9; k++) wr(1, k, tb_w[k]);
    wr(1, 9, tb_bias);
  endtask

  task automatic wait_done(string name);
    int cyc = 0;
    while (!done && cyc < 450) begin
      @(posedge clk); #1 cyc++;
    end
    chk({name, "_latency"}, cyc, 406);
  endtask

  task automatic run(string name);
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    chk({name, "_done_drop"}, done, 0);
    wait_done(name);
  endtask

  task automatic chk_outs(string name, logic [71:0] e);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); rd_addr = 4'(k);
      #1 chk($sformatf("%s_out%0d", name, k), data_out, e[k*8 +: 8]);
    end
  endtask

  task automatic set_vec(vec_t v);
    for (int i = 0; i < 64; i++) tb_img[i] = v.pmode == 0 ? i % 32 : v.pmode == 1 ? 10 : 255;
    for (int k = 0; k < 9; k++) tb_w[k] = v.wmode == 0 ? (k == 4 ? 1 : 0) : v.wfill;
    tb_bias = v.bias;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, -5, {8'd17, 8'd15, 8'd13, 8'd25, 8'd23, 8'd21, 8'd17, 8'd15, 8'd13}};
    vecs[1] = '{1, 1, 1, 0, {9{8'd90}}};
    vecs[2] = '{1, 1, -1, 0, {9{8'd0}}};
    vecs[3] = '{2, 1, 127, 127, {9{8'd255}}};
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("reset_done", done, 0);
    chk_outs("reset", '0);
    @(negedge clk); rd_addr = 4'd12;
    #1 chk("reset_rd_oob", data_out, 0);

    foreach (vecs[n]) begin
      set_vec(vecs[n]);
      load();
      run($sformatf("vec%0d", n));
      chk_outs($sformatf("vec%0d", n), vecs[n].exp);
      chk($sformatf("vec%0d_model", n), int'(model() == vecs[n].exp), 1);
    end
    @(negedge clk); rd_addr = 4'd9;
    #1 chk("rd_oob_9", data_out, 0);

    // Busy: restart and image/bias writes during CONV must be ignored.
    set_vec(vecs[0]);
    load();
    begin
      int cyc = 0;
      @(negedge clk); start = 1;
      @(posedge clk); #1 start = 0;
      while (!done && cyc < 450) begin
        @(negedge clk);
        wr_en = (cyc == 50 || cyc == 51); mem_select = (cyc == 51);
        wr_addr = cyc == 51 ? 6'd9 : 6'd18; data_in = 8'd200;
        start = (cyc == 60 || cyc == 380);
        @(posedge clk); #1 cyc++;
      end
      wr_en = 0; start = 0;
      chk("busy_latency", cyc, 406);
    end
    chk_outs("busy", vecs[0].exp);

    // Reset partway through CONV aborts and clears the output RAM.
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    repeat (100) @(posedge clk);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("abort_done", done, 0);
    repeat (30) @(posedge clk);
    #1 chk("abort_done_stays", done, 0);
    chk_outs("abort", '0);
    run("after_abort");
    chk_outs("after_abort", vecs[0].exp);

    // Write and start in the same IDLE cycle: the new bias is used.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    wr_en = 1; mem_select = 1; wr_addr = 6'd9; data_in = 8'd50; start = 1;
    tb_bias = 50;
    @(posedge clk); #1 start = 0; wr_en = 0;
    wait_done("simul");
    chk_outs("simul", model());

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) tb_img[i] = int'($urandom_range(0, 255));
      for (int k = 0; k < 9; k++) tb_w[k] = int'($urandom_range(0, 16)) - 8;
      tb_bias = int'($urandom_range(0, 255)) - 128;
      load();
      run($sformatf("rand%0d", t));
      chk_outs($sformatf("rand%0d", t), model());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
